// File: rtl/m_cache_refill.sv
// Miss handler for the 4-word line cache: fetches a 128-bit line word by word,
// installs it into the cache and returns the missed word.
module m_cache_refill #(
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_req,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic                  i_hit,
    output logic                  o_stall,
    output logic                  o_mem_req,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    input  logic                  i_mem_gnt,
    input  logic                  i_mem_rvalid,
    input  logic [31:0]           i_mem_rdata,
    output logic                  o_bwe,
    output logic [ADDR_WIDTH-1:0] o_waddr,
    output logic [127:0]          o_bdata,
    output logic                  o_rvalid,
    output logic [31:0]           o_rdata,
    output logic [31:0]           o_miss_cnt
);

    localparam int unsigned WORDS  = 4;
    localparam int unsigned WORD_W = 32;
    localparam int unsigned CNT_W  = 3;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_FETCH   = 2'd1,
        S_INSTALL = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t                          state_q, state_d;
    logic [ADDR_WIDTH-1:0]           base_q;
    logic [1:0]                      widx_q;
    logic [CNT_W-1:0]                issue_cnt_q;
    logic [CNT_W-1:0]                resp_cnt_q;
    logic [WORDS-1:0][WORD_W-1:0]    slot_q, slot_d;
    logic [31:0]                     miss_cnt_q;
    logic                            miss_c;
    logic                            mem_req_c;
    logic                            rsp_c;
    logic                            unused_addr_bits;

    assign unused_addr_bits = ^i_addr[1:0];

    // Next state, request decode and the line as it will look after this cycle's response
    always_comb begin
        state_d   = state_q;
        miss_c    = (state_q == S_IDLE) && i_req && !i_hit;
        mem_req_c = (state_q == S_FETCH) && (issue_cnt_q < CNT_W'(WORDS));
        rsp_c     = (state_q == S_FETCH) && i_mem_rvalid;
        slot_d    = slot_q;
        if (rsp_c) begin
            slot_d[resp_cnt_q[1:0]] = i_mem_rdata;
        end
        case (state_q)
            S_IDLE:    if (miss_c) state_d = S_FETCH;
            S_FETCH:   if (rsp_c && (resp_cnt_q == CNT_W'(WORDS - 1))) state_d = S_INSTALL;
            S_INSTALL: state_d = S_DONE;
            S_DONE:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    assign o_mem_req  = mem_req_c;
    assign o_mem_addr = mem_req_c ? (base_q + ADDR_WIDTH'({issue_cnt_q[1:0], 2'b00})) : '0;
    assign o_stall    = (state_q == S_FETCH) || (state_q == S_INSTALL) || miss_c;
    assign o_miss_cnt = miss_cnt_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= S_IDLE;
            base_q      <= '0;
            widx_q      <= '0;
            issue_cnt_q <= '0;
            resp_cnt_q  <= '0;
            slot_q      <= '0;
            miss_cnt_q  <= '0;
            o_bwe       <= 1'b0;
            o_waddr     <= '0;
            o_bdata     <= '0;
            o_rvalid    <= 1'b0;
            o_rdata     <= '0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
            if (miss_c) begin
                base_q      <= {i_addr[ADDR_WIDTH-1:4], 4'b0000};
                widx_q      <= i_addr[3:2];
                issue_cnt_q <= '0;
                resp_cnt_q  <= '0;
            end else begin
                if (mem_req_c && i_mem_gnt) issue_cnt_q <= issue_cnt_q + CNT_W'(1);
                if (rsp_c)                  resp_cnt_q  <= resp_cnt_q + CNT_W'(1);
            end
            // Install uses the line including the response landing this cycle
            o_bwe <= (state_d == S_INSTALL);
            if (state_d == S_INSTALL) begin
                o_waddr <= base_q;
                o_bdata <= slot_d;
            end
            o_rvalid <= (state_d == S_DONE);
            if (state_d == S_DONE) begin
                o_rdata    <= slot_q[widx_q];
                miss_cnt_q <= miss_cnt_q + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_m_cache_refill.sv
// Directed bench for m_cache_refill with an in-order, programmable-latency memory responder.
module tb_m_cache_refill;

    localparam int unsigned AW = 32;

    logic          i_clk;
    logic          i_rst;
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic          i_hit;
    logic          o_stall;
    logic          o_mem_req;
    logic [AW-1:0] o_mem_addr;
    logic          i_mem_gnt;
    logic          i_mem_rvalid;
    logic [31:0]   i_mem_rdata;
    logic          o_bwe;
    logic [AW-1:0] o_waddr;
    logic [127:0]  o_bdata;
    logic          o_rvalid;
    logic [31:0]   o_rdata;
    logic [31:0]   o_miss_cnt;

    m_cache_refill #(.ADDR_WIDTH(AW)) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_req        (i_req),
        .i_addr       (i_addr),
        .i_hit        (i_hit),
        .o_stall      (o_stall),
        .o_mem_req    (o_mem_req),
        .o_mem_addr   (o_mem_addr),
        .i_mem_gnt    (i_mem_gnt),
        .i_mem_rvalid (i_mem_rvalid),
        .i_mem_rdata  (i_mem_rdata),
        .o_bwe        (o_bwe),
        .o_waddr      (o_waddr),
        .o_bdata      (o_bdata),
        .o_rvalid     (o_rvalid),
        .o_rdata      (o_rdata),
        .o_miss_cnt   (o_miss_cnt)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    int nvec = 0;
    int nerr = 0;

    // Responder configuration (written by the main thread only)
    logic [31:0] mem_base = 32'h0;
    int          dly [4]  = '{1, 1, 1, 1};
    int          hold_idx = 0;
    int          hold_len = 0;

    typedef struct packed {
        logic [31:0] data;
        int          due;
    } rsp_t;
    rsp_t rq [$];
    int   held = 0;

    // Memory: word k of a line reads mem_base + k; responses strictly in order
    initial begin
        i_mem_gnt    = 1'b1;
        i_mem_rvalid = 1'b0;
        i_mem_rdata  = '0;
        forever begin
            @(negedge i_clk);
            if (i_mem_rvalid && rq.size() > 0) rq.delete(0);
            if (o_mem_req && i_mem_gnt) begin
                rq.push_back('{mem_base + 32'(o_mem_addr[3:2]), cyc + dly[o_mem_addr[3:2]]});
                held = 0;
            end else if (o_mem_req) begin
                held++;
            end
            @(posedge i_clk);
            #1;
            i_mem_gnt = !(o_mem_req && (int'(o_mem_addr[3:2]) == hold_idx) && (held < hold_len));
            if (rq.size() > 0 && rq[0].due <= cyc) begin
                i_mem_rvalid = 1'b1;
                i_mem_rdata  = rq[0].data;
            end else begin
                i_mem_rvalid = 1'b0;
                i_mem_rdata  = '0;
            end
        end
    end

    // Per-miss observations, indexed relative to the miss-detect cycle
    logic [63:0]   stall_log;
    logic [AW-1:0] addr_log [64];
    logic [AW-1:0] iss_addr [8];
    int            iss_rel  [8];
    int            rv_rel   [8];
    int            n_iss, n_rv, req_cnt, bwe_cnt, done_cnt, bwe_rel, done_rel;
    logic [AW-1:0] s_waddr;
    logic [127:0]  s_bdata;
    logic [31:0]   s_rdata, s_miss;

    task automatic run_miss(input logic [31:0] addr, input bit pulse);
        n_iss = 0; n_rv = 0; req_cnt = 0; bwe_cnt = 0; done_cnt = 0;
        bwe_rel = -1; done_rel = -1; stall_log = '0;
        s_waddr = '0; s_bdata = '0; s_rdata = '0; s_miss = '0;
        @(posedge i_clk);
        #1;
        i_req = 1'b1; i_hit = 1'b0; i_addr = addr;
        for (int k = 0; k < 64; k++) begin
            @(negedge i_clk);
            stall_log[k] = o_stall;
            addr_log[k]  = o_mem_addr;
            if (o_mem_req) req_cnt++;
            if (o_mem_req && i_mem_gnt && n_iss < 8) begin
                iss_addr[n_iss] = o_mem_addr; iss_rel[n_iss] = k; n_iss++;
            end
            if (i_mem_rvalid && n_rv < 8) begin
                rv_rel[n_rv] = k; n_rv++;
            end
            if (o_bwe) begin
                bwe_cnt++; bwe_rel = k; s_waddr = o_waddr; s_bdata = o_bdata;
            end
            if (o_rvalid) begin
                done_cnt++; done_rel = k; s_rdata = o_rdata; s_miss = o_miss_cnt;
            end
            @(posedge i_clk);
            #1;
            i_req = pulse && (k == 1 || k == 3);
            if (done_rel >= 0) break;
        end
        i_req = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        @(negedge i_clk);
        nvec++;
        if ({o_stall, o_mem_req, o_bwe, o_rvalid} !== 4'b0) begin
            nerr++; $display("FAIL reset_flags: got %b expected 0000", {o_stall, o_mem_req, o_bwe, o_rvalid});
        end
        nvec++;
        if ({o_mem_addr, o_waddr, o_rdata, o_miss_cnt} !== '0) begin
            nerr++; $display("FAIL reset_words: got %h %h %h %h expected all 0", o_mem_addr, o_waddr, o_rdata, o_miss_cnt);
        end
        nvec++;
        if (o_bdata !== 128'h0) begin
            nerr++; $display("FAIL reset_bdata: got %h expected 0", o_bdata);
        end
    endtask

    task automatic test_zero_wait();
        mem_base = 32'h0000_00A0; dly = '{1, 1, 1, 1}; hold_len = 0;
        run_miss(32'h0000_1238, 1'b0);
        nvec++;
        if (stall_log[0] !== 1'b1) begin
            nerr++; $display("FAIL zw_stall_T: got %b expected 1", stall_log[0]);
        end
        nvec++;
        if (n_iss !== 4) begin
            nerr++; $display("FAIL zw_grants: got %0d expected 4", n_iss);
        end
        for (int i = 0; i < 4; i++) begin
            nvec++;
            if (iss_addr[i] !== 32'h1230 + 32'(4 * i) || iss_rel[i] !== i + 1) begin
                nerr++; $display("FAIL zw_issue%0d: got %h@T+%0d expected %h@T+%0d",
                                 i, iss_addr[i], iss_rel[i], 32'h1230 + 32'(4 * i), i + 1);
            end
        end
        nvec++;
        if (rv_rel[3] !== 5) begin
            nerr++; $display("FAIL zw_last_rvalid: got T+%0d expected T+5", rv_rel[3]);
        end
        nvec++;
        if (bwe_cnt !== 1 || bwe_rel !== 6 || s_waddr !== 32'h1230) begin
            nerr++; $display("FAIL zw_install: got cnt %0d T+%0d addr %h expected 1 T+6 00001230", bwe_cnt, bwe_rel, s_waddr);
        end
        nvec++;
        if (s_bdata !== 128'h000000A3_000000A2_000000A1_000000A0) begin
            nerr++; $display("FAIL zw_bdata: got %h expected 000000a3000000a2000000a1000000a0", s_bdata);
        end
        nvec++;
        if (done_rel !== 7 || s_rdata !== 32'hA2 || s_miss !== 32'd1) begin
            nerr++; $display("FAIL zw_done: got T+%0d rdata %h cnt %0d expected T+7 000000a2 1", done_rel, s_rdata, s_miss);
        end
        nvec++;
        if (stall_log[7:6] !== 2'b01) begin
            nerr++; $display("FAIL zw_stall_release: got %b expected 01", stall_log[7:6]);
        end
    endtask

    task automatic test_hit();
        int n_stall = 0, n_req = 0, n_bwe = 0;
        @(posedge i_clk);
        #1;
        i_req = 1'b1; i_hit = 1'b1; i_addr = 32'h0000_2000;
        for (int k = 0; k < 20; k++) begin
            @(negedge i_clk);
            if (o_stall) n_stall++;
            if (o_mem_req) n_req++;
            if (o_bwe) n_bwe++;
        end
        @(posedge i_clk);
        #1;
        i_req = 1'b0; i_hit = 1'b0;
        nvec++;
        if (n_stall !== 0) begin
            nerr++; $display("FAIL hit_stall: got %0d cycles expected 0", n_stall);
        end
        nvec++;
        if (n_req !== 0 || n_bwe !== 0) begin
            nerr++; $display("FAIL hit_traffic: got req %0d bwe %0d expected 0 0", n_req, n_bwe);
        end
        nvec++;
        if (o_miss_cnt !== 32'd1) begin
            nerr++; $display("FAIL hit_cnt: got %0d expected 1", o_miss_cnt);
        end
    endtask

    task automatic test_wait_states();
        mem_base = 32'hC000_0000; dly = '{1, 5, 2, 3}; hold_idx = 1; hold_len = 3;
        run_miss(32'h0000_0A04, 1'b0);
        hold_len = 0;
        nvec++;
        if (iss_rel[0] !== 1 || iss_rel[1] !== 5 || iss_rel[2] !== 6 || iss_rel[3] !== 7) begin
            nerr++; $display("FAIL ws_grants: got %0d %0d %0d %0d expected 1 5 6 7", iss_rel[0], iss_rel[1], iss_rel[2], iss_rel[3]);
        end
        for (int k = 2; k <= 4; k++) begin
            nvec++;
            if (addr_log[k] !== 32'h0000_0A04) begin
                nerr++; $display("FAIL ws_addr_hold_T%0d: got %h expected 00000a04", k, addr_log[k]);
            end
        end
        nvec++;
        if (req_cnt !== 7) begin
            nerr++; $display("FAIL ws_req_cycles: got %0d expected 7", req_cnt);
        end
        nvec++;
        if (rv_rel[1] !== 10 || rv_rel[2] !== 11 || rv_rel[3] !== 12) begin
            nerr++; $display("FAIL ws_rvalid: got %0d %0d %0d expected 10 11 12", rv_rel[1], rv_rel[2], rv_rel[3]);
        end
        nvec++;
        if (bwe_rel !== 13 || bwe_cnt !== 1 || s_waddr !== 32'h0000_0A00) begin
            nerr++; $display("FAIL ws_install: got T+%0d cnt %0d addr %h expected T+13 1 00000a00", bwe_rel, bwe_cnt, s_waddr);
        end
        nvec++;
        if (s_bdata !== 128'hC0000003_C0000002_C0000001_C0000000) begin
            nerr++; $display("FAIL ws_bdata: got %h expected c0000003c0000002c0000001c0000000", s_bdata);
        end
        nvec++;
        if (done_rel !== 14 || s_rdata !== 32'hC000_0001 || s_miss !== 32'd2) begin
            nerr++; $display("FAIL ws_done: got T+%0d %h cnt %0d expected T+14 c0000001 2", done_rel, s_rdata, s_miss);
        end
    endtask

    task automatic test_mid_reset();
        int n_bad = 0;
        mem_base = 32'h7700_0000; dly = '{1, 1, 1, 1};
        @(posedge i_clk);
        #1;
        i_req = 1'b1; i_hit = 1'b0; i_addr = 32'h0000_3330;
        for (int k = 1; k <= 4; k++) begin
            @(posedge i_clk);
            #1;
            i_req = 1'b0;
        end
        i_rst = 1'b1;
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        @(negedge i_clk);
        nvec++;
        if ({o_stall, o_mem_req, o_bwe, o_rvalid} !== 4'b0) begin
            nerr++; $display("FAIL mr_flags: got %b expected 0000", {o_stall, o_mem_req, o_bwe, o_rvalid});
        end
        nvec++;
        if ({o_mem_addr, o_waddr, o_rdata, o_miss_cnt} !== '0 || o_bdata !== 128'h0) begin
            nerr++; $display("FAIL mr_words: got %h %h %h %h %h expected all 0", o_mem_addr, o_waddr, o_rdata, o_miss_cnt, o_bdata);
        end
        for (int k = 0; k < 12; k++) begin
            if (o_stall || o_mem_req || o_bwe || o_rvalid) n_bad++;
            @(negedge i_clk);
        end
        nvec++;
        if (n_bad !== 0 || o_miss_cnt !== 32'd0) begin
            nerr++; $display("FAIL mr_quiet: got %0d active cycles cnt %0d expected 0 0", n_bad, o_miss_cnt);
        end
        mem_base = 32'h1111_0000;
        run_miss(32'h0000_4004, 1'b0);
        nvec++;
        if (bwe_rel !== 6 || s_waddr !== 32'h0000_4000 || s_bdata !== 128'h11110003_11110002_11110001_11110000) begin
            nerr++; $display("FAIL mr_install: got T+%0d %h %h expected T+6 00004000 11110003111100021111000111110000", bwe_rel, s_waddr, s_bdata);
        end
        nvec++;
        if (s_rdata !== 32'h1111_0001 || s_miss !== 32'd1) begin
            nerr++; $display("FAIL mr_done: got %h cnt %0d expected 11110001 1", s_rdata, s_miss);
        end
    endtask

    task automatic test_stall_pulses();
        mem_base = 32'h5000_0000; dly = '{1, 1, 1, 1};
        run_miss(32'h0000_FFFC, 1'b1);
        nvec++;
        if (n_iss !== 4 || req_cnt !== 4) begin
            nerr++; $display("FAIL st_fetches: got grants %0d req %0d expected 4 4", n_iss, req_cnt);
        end
        nvec++;
        if (stall_log[7:0] !== 8'b0111_1111) begin
            nerr++; $display("FAIL st_stall_window: got %b expected 01111111", stall_log[7:0]);
        end
        nvec++;
        if (done_rel !== 7 || s_rdata !== 32'h5000_0003 || s_miss !== 32'd2) begin
            nerr++; $display("FAIL st_done: got T+%0d %h cnt %0d expected T+7 50000003 2", done_rel, s_rdata, s_miss);
        end
        repeat (3) @(negedge i_clk);
        nvec++;
        if (o_stall !== 1'b0 || o_mem_req !== 1'b0) begin
            nerr++; $display("FAIL st_idle_after: got stall %b req %b expected 0 0", o_stall, o_mem_req);
        end
    endtask

    task automatic test_wrap();
        @(negedge i_clk);
        force dut.miss_cnt_q = 32'hFFFF_FFFF;
        @(negedge i_clk);
        release dut.miss_cnt_q;
        @(negedge i_clk);
        nvec++;
        if (o_miss_cnt !== 32'hFFFF_FFFF) begin
            nerr++; $display("FAIL wrap_preload: got %h expected ffffffff", o_miss_cnt);
        end
        mem_base = 32'h0000_0009;
        run_miss(32'h0000_0020, 1'b0);
        nvec++;
        if (done_rel !== 7 || s_miss !== 32'd0 || s_rdata !== 32'h0000_0009) begin
            nerr++; $display("FAIL wrap_count: got T+%0d cnt %h rdata %h expected T+7 00000000 00000009", done_rel, s_miss, s_rdata);
        end
    endtask

    initial begin
        i_rst  = 1'b1;
        i_req  = 1'b0;
        i_hit  = 1'b0;
        i_addr = '0;
        test_reset();
        test_zero_wait();
        test_hit();
        test_wait_states();
        test_mid_reset();
        test_stall_pulses();
        test_wrap();
        repeat (2) @(posedge i_clk);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
